// File: rtl/fv_pkg.sv
// ---------------------------------------------------------------------------
// fv_pkg
// Shared constants and helpers for the forward_view ground renderer.
//   - screen / world geometry (active area, horizon, depth constant, tiles)
//   - colour constants used by the pixel selector
//   - angle width and Q1.8 trig fraction width
//   - quadrant_t: which quarter-wave mirroring the trig LUT applies
//   - recip_depth(): builds one entry of the reciprocal-depth ROM
// ---------------------------------------------------------------------------
package fv_pkg;

    // Screen and world geometry
    localparam int H_ACTIVE  = 1024;
    localparam int V_ACTIVE  = 768;
    localparam int HORIZON   = 384;
    localparam int DEPTH_K   = 16384;
    localparam int TILE_LOG2 = 6;
    localparam int OPP_HALF  = 32;

    // Largest representable distance and world coordinate
    localparam int DEPTH_MAX = 2047;
    localparam int WORLD_MAX = 2047;

    // One ROM entry per ground row below the horizon; entry 0 is never a
    // real row and holds zero
    localparam int RECIP_N = V_ACTIVE - HORIZON;

    // Heading width and signed Q1.8 trig format (-256..256 needs 10 bits)
    localparam int ANGLE_W   = 9;
    localparam int TRIG_FRAC = 8;
    localparam int TRIG_W    = TRIG_FRAC + 2;

    // Output colours, 4:4:4 RGB
    localparam logic [11:0] SKY     = 12'h6AF;
    localparam logic [11:0] OFFMAP  = 12'h444;
    localparam logic [11:0] CHECK_A = 12'h0A0;
    localparam logic [11:0] CHECK_B = 12'h070;
    localparam logic [11:0] OPP     = 12'hF00;
    localparam logic [11:0] BLANK   = 12'h000;

    // Quarter of the circle a heading falls in; 0 covers 0..90 inclusive
    typedef enum logic [1:0] {
        QUAD_0,
        QUAD_1,
        QUAD_2,
        QUAD_3
    } quadrant_t;

    // Distance to the ground for a row r below the horizon, saturated so
    // rows very close to the horizon do not overflow 11 bits
    function automatic logic [10:0] recip_depth(input int r);
        int q;
        if (r <= 0) begin
            return 11'd0;
        end
        q = DEPTH_K / r;
        if (q > DEPTH_MAX) begin
            q = DEPTH_MAX;
        end
        return 11'(q);
    endfunction

endpackage

// File: rtl/fv_trig_lut.sv
// ---------------------------------------------------------------------------
// fv_trig_lut
// Converts a heading in degrees (already folded into 0..359) into signed
// Q1.8 sine and cosine. Only a quarter wave (0..90 degrees) is stored; the
// other three quarters are produced by mirroring the index and flipping
// the sign. Results are registered, so this is one pipeline stage.
//
// Ports:
//   clk_in   - pixel clock
//   rst_in   - asynchronous active-high reset, clears both outputs
//   angle_in - heading 0..359 degrees
//   sin_out  - registered sin(angle) * 256, signed
//   cos_out  - registered cos(angle) * 256, signed
// ---------------------------------------------------------------------------
module fv_trig_lut
    import fv_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [ANGLE_W-1:0]       angle_in,
    output logic signed [TRIG_W-1:0] sin_out,
    output logic signed [TRIG_W-1:0] cos_out
);

    // round(256 * sin(idx degrees)) for idx 0..90
    function automatic logic [8:0] quarter_sin(input logic [6:0] idx);
        logic [8:0] v;
        case (idx)
            7'd0:  v = 9'd0;   7'd1:  v = 9'd4;   7'd2:  v = 9'd9;   7'd3:  v = 9'd13;
            7'd4:  v = 9'd18;  7'd5:  v = 9'd22;  7'd6:  v = 9'd27;  7'd7:  v = 9'd31;
            7'd8:  v = 9'd36;  7'd9:  v = 9'd40;  7'd10: v = 9'd44;  7'd11: v = 9'd49;
            7'd12: v = 9'd53;  7'd13: v = 9'd58;  7'd14: v = 9'd62;  7'd15: v = 9'd66;
            7'd16: v = 9'd71;  7'd17: v = 9'd75;  7'd18: v = 9'd79;  7'd19: v = 9'd83;
            7'd20: v = 9'd88;  7'd21: v = 9'd92;  7'd22: v = 9'd96;  7'd23: v = 9'd100;
            7'd24: v = 9'd104; 7'd25: v = 9'd108; 7'd26: v = 9'd112; 7'd27: v = 9'd116;
            7'd28: v = 9'd120; 7'd29: v = 9'd124; 7'd30: v = 9'd128; 7'd31: v = 9'd132;
            7'd32: v = 9'd136; 7'd33: v = 9'd139; 7'd34: v = 9'd143; 7'd35: v = 9'd147;
            7'd36: v = 9'd150; 7'd37: v = 9'd154; 7'd38: v = 9'd158; 7'd39: v = 9'd161;
            7'd40: v = 9'd165; 7'd41: v = 9'd168; 7'd42: v = 9'd171; 7'd43: v = 9'd175;
            7'd44: v = 9'd178; 7'd45: v = 9'd181; 7'd46: v = 9'd184; 7'd47: v = 9'd187;
            7'd48: v = 9'd190; 7'd49: v = 9'd193; 7'd50: v = 9'd196; 7'd51: v = 9'd199;
            7'd52: v = 9'd202; 7'd53: v = 9'd204; 7'd54: v = 9'd207; 7'd55: v = 9'd210;
            7'd56: v = 9'd212; 7'd57: v = 9'd215; 7'd58: v = 9'd217; 7'd59: v = 9'd219;
            7'd60: v = 9'd222; 7'd61: v = 9'd224; 7'd62: v = 9'd226; 7'd63: v = 9'd228;
            7'd64: v = 9'd230; 7'd65: v = 9'd232; 7'd66: v = 9'd234; 7'd67: v = 9'd236;
            7'd68: v = 9'd237; 7'd69: v = 9'd239; 7'd70: v = 9'd241; 7'd71: v = 9'd242;
            7'd72: v = 9'd243; 7'd73: v = 9'd245; 7'd74: v = 9'd246; 7'd75: v = 9'd247;
            7'd76: v = 9'd248; 7'd77: v = 9'd249; 7'd78: v = 9'd250; 7'd79: v = 9'd251;
            7'd80: v = 9'd252; 7'd81: v = 9'd253; 7'd82: v = 9'd254; 7'd83: v = 9'd254;
            7'd84: v = 9'd255; 7'd85: v = 9'd255; 7'd86: v = 9'd255; 7'd87: v = 9'd256;
            7'd88: v = 9'd256; 7'd89: v = 9'd256;
            default: v = 9'd256;
        endcase
        return v;
    endfunction

    quadrant_t  quad;
    logic [6:0] sin_idx;
    logic [6:0] cos_idx;
    logic       sin_neg;
    logic       cos_neg;
    logic [8:0] sin_mag;
    logic [8:0] cos_mag;

    // Decide which quarter the heading is in. The boundaries 90/180/270
    // belong to the lower quarter so each mirrored index stays in 0..90.
    always_comb begin
        quad = QUAD_0;
        if (angle_in > 9'd270) begin
            quad = QUAD_3;
        end else if (angle_in > 9'd180) begin
            quad = QUAD_2;
        end else if (angle_in > 9'd90) begin
            quad = QUAD_1;
        end
    end

    // Mirror the heading into the stored quarter wave. cos(a) is looked up
    // as sin(90 - a) so a single table serves both outputs.
    always_comb begin
        sin_idx = 7'(angle_in);
        cos_idx = 7'(9'd90 - angle_in);
        sin_neg = 1'b0;
        cos_neg = 1'b0;
        case (quad)
            QUAD_1: begin
                sin_idx = 7'(9'd180 - angle_in);
                cos_idx = 7'(angle_in - 9'd90);
                cos_neg = 1'b1;
            end
            QUAD_2: begin
                sin_idx = 7'(angle_in - 9'd180);
                cos_idx = 7'(9'd270 - angle_in);
                sin_neg = 1'b1;
                cos_neg = 1'b1;
            end
            QUAD_3: begin
                sin_idx = 7'(9'd360 - angle_in);
                cos_idx = 7'(angle_in - 9'd270);
                sin_neg = 1'b1;
            end
            default: begin
            end
        endcase
        sin_mag = quarter_sin(sin_idx);
        cos_mag = quarter_sin(cos_idx);
    end

    // Apply the quadrant sign and register the result
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sin_out <= '0;
            cos_out <= '0;
        end else begin
            sin_out <= sin_neg ? -$signed({1'b0, sin_mag}) : $signed({1'b0, sin_mag});
            cos_out <= cos_neg ? -$signed({1'b0, cos_mag}) : $signed({1'b0, cos_mag});
        end
    end

endmodule

// File: rtl/forward_view.sv
// ---------------------------------------------------------------------------
// forward_view
// Mode-7 style ground renderer for the first-person pane. Every clock it
// takes one raster position, projects it onto the 2048x2048 world plane
// from the player's position and heading, and produces a 12-bit colour:
// blanking, sky, off-map grey, opponent marker, or a two-tone checker.
// Fixed latency of three clocks; a new pixel is accepted every clock.
//
// Pipeline:
//   stage 1 - trig lookup, reciprocal depth lookup, screen offset, flags
//   stage 2 - lateral offset and the four rotation products
//   stage 3 - world coordinates
//   output  - colour selection into pixel_out
//
// Ports:
//   clk_in      - pixel clock
//   rst_in      - asynchronous active-high reset, flushes the pipeline
//   hcount_in   - current column
//   vcount_in   - current row
//   direction   - player heading in degrees, 0 = +x, 90 = +y (0..511)
//   player_x/y  - player world position
//   opponent_x/y- opponent world position (used only with the macro below)
//   pixel_out   - RGB 4:4:4 colour
//
// Build option: define FORWARD_VIEW_OPPONENT_EN to draw the opponent marker.
// ---------------------------------------------------------------------------
module forward_view
    import fv_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [8:0]  direction,
    input  logic [10:0] player_x,
    input  logic [10:0] player_y,
    input  logic [10:0] opponent_x,
    input  logic [10:0] opponent_y,
    output logic [11:0] pixel_out
);

    // ---------------------------------------------------------------
    // Stage 1: lookups
    // ---------------------------------------------------------------

    logic [ANGLE_W-1:0]       dir_norm;
    logic signed [TRIG_W-1:0] sin_s1;
    logic signed [TRIG_W-1:0] cos_s1;

    // Headings 360..511 wrap back onto 0..151
    always_comb begin
        dir_norm = direction;
        if (direction >= 9'd360) begin
            dir_norm = direction - 9'd360;
        end
    end

    fv_trig_lut u_trig (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .angle_in (dir_norm),
        .sin_out  (sin_s1),
        .cos_out  (cos_s1)
    );

    // Reciprocal-depth ROM, filled with constants at elaboration
    logic [10:0] recip_rom [RECIP_N];

    for (genvar i = 0; i < RECIP_N; i++) begin : g_recip
        assign recip_rom[i] = recip_depth(i);
    end

    logic               blank_next;
    logic               sky_next;
    logic [8:0]         r_idx;
    logic signed [11:0] h_next;

    // Classify the raster position and derive the ROM row index. The index
    // is forced to zero outside the ground area so the ROM never sees a
    // row it was not built for.
    always_comb begin
        blank_next = (hcount_in >= 11'(H_ACTIVE)) || (vcount_in >= 10'(V_ACTIVE));
        sky_next   = (vcount_in <= 10'(HORIZON));
        r_idx      = '0;
        if (!blank_next && !sky_next) begin
            r_idx = 9'(vcount_in - 10'(HORIZON));
        end
        h_next = $signed({1'b0, hcount_in}) - $signed(12'(H_ACTIVE / 2));
    end

    logic               valid_s1;
    logic               blank_s1;
    logic               sky_s1;
    logic [10:0]        d_s1;
    logic signed [11:0] h_s1;
    logic [10:0]        px_s1;
    logic [10:0]        py_s1;

    // Stage 1 registers, aligned with the trig outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_s1 <= 1'b0;
            blank_s1 <= 1'b0;
            sky_s1   <= 1'b0;
            d_s1     <= '0;
            h_s1     <= '0;
            px_s1    <= '0;
            py_s1    <= '0;
        end else begin
            valid_s1 <= 1'b1;
            blank_s1 <= blank_next;
            sky_s1   <= sky_next;
            d_s1     <= recip_rom[r_idx];
            h_s1     <= h_next;
            px_s1    <= player_x;
            py_s1    <= player_y;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: lateral offset and rotation products
    // ---------------------------------------------------------------

    logic signed [31:0] h_ext;
    logic signed [31:0] d_ext;
    logic signed [31:0] sin_ext;
    logic signed [31:0] cos_ext;
    logic signed [31:0] lat;

    // 32-bit signed working width keeps every product exact
    always_comb begin
        h_ext   = 32'(h_s1);
        d_ext   = $signed({21'd0, d_s1});
        sin_ext = 32'(sin_s1);
        cos_ext = 32'(cos_s1);
        lat     = (h_ext * d_ext) >>> 9;
    end

    logic               valid_s2;
    logic               blank_s2;
    logic               sky_s2;
    logic signed [31:0] dcos_s2;
    logic signed [31:0] dsin_s2;
    logic signed [31:0] lsin_s2;
    logic signed [31:0] lcos_s2;
    logic [10:0]        px_s2;
    logic [10:0]        py_s2;

    // Stage 2 registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_s2 <= 1'b0;
            blank_s2 <= 1'b0;
            sky_s2   <= 1'b0;
            dcos_s2  <= '0;
            dsin_s2  <= '0;
            lsin_s2  <= '0;
            lcos_s2  <= '0;
            px_s2    <= '0;
            py_s2    <= '0;
        end else begin
            valid_s2 <= valid_s1;
            blank_s2 <= blank_s1;
            sky_s2   <= sky_s1;
            dcos_s2  <= d_ext * cos_ext;
            dsin_s2  <= d_ext * sin_ext;
            lsin_s2  <= lat * sin_ext;
            lcos_s2  <= lat * cos_ext;
            px_s2    <= px_s1;
            py_s2    <= py_s1;
        end
    end

    // ---------------------------------------------------------------
    // Stage 3: world coordinates
    // ---------------------------------------------------------------

    logic               valid_s3;
    logic               blank_s3;
    logic               sky_s3;
    logic signed [31:0] wx_s3;
    logic signed [31:0] wy_s3;

    // Rotate (depth, lateral) by the heading and add the player position.
    // The sum is scaled back from Q1.8 after subtraction so rounding only
    // happens once per axis.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_s3 <= 1'b0;
            blank_s3 <= 1'b0;
            sky_s3   <= 1'b0;
            wx_s3    <= '0;
            wy_s3    <= '0;
        end else begin
            valid_s3 <= valid_s2;
            blank_s3 <= blank_s2;
            sky_s3   <= sky_s2;
            wx_s3    <= $signed({21'd0, px_s2}) + ((dcos_s2 - lsin_s2) >>> TRIG_FRAC);
            wy_s3    <= $signed({21'd0, py_s2}) + ((dsin_s2 + lcos_s2) >>> TRIG_FRAC);
        end
    end

    // ---------------------------------------------------------------
    // Opponent position, carried alongside the pixel when enabled
    // ---------------------------------------------------------------

    logic opp_hit;

`ifdef FORWARD_VIEW_OPPONENT_EN
    logic [10:0]        ox_s1, oy_s1, ox_s2, oy_s2, ox_s3, oy_s3;
    logic signed [31:0] opp_dx;
    logic signed [31:0] opp_dy;

    // Opponent coordinates follow the same three-stage path so a mid-frame
    // move lines up with the pixel it was sampled with
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ox_s1 <= '0;
            oy_s1 <= '0;
            ox_s2 <= '0;
            oy_s2 <= '0;
            ox_s3 <= '0;
            oy_s3 <= '0;
        end else begin
            ox_s1 <= opponent_x;
            oy_s1 <= opponent_y;
            ox_s2 <= ox_s1;
            oy_s2 <= oy_s1;
            ox_s3 <= ox_s2;
            oy_s3 <= oy_s2;
        end
    end

    assign opp_dx  = wx_s3 - $signed({21'd0, ox_s3});
    assign opp_dy  = wy_s3 - $signed({21'd0, oy_s3});
    assign opp_hit = (opp_dx > -OPP_HALF) && (opp_dx < OPP_HALF) &&
                     (opp_dy > -OPP_HALF) && (opp_dy < OPP_HALF);
`else
    logic unused_opponent;

    assign unused_opponent = ^{opponent_x, opponent_y};
    assign opp_hit         = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Output: colour selection
    // ---------------------------------------------------------------

    logic        offmap;
    logic        tile_odd;
    logic [11:0] colour_next;

    // Priority: blanking, sky, off-map, opponent, checker
    always_comb begin
        offmap   = (wx_s3 < 0) || (wx_s3 > WORLD_MAX) ||
                   (wy_s3 < 0) || (wy_s3 > WORLD_MAX);
        tile_odd = wx_s3[TILE_LOG2] ^ wy_s3[TILE_LOG2];
        if (blank_s3) begin
            colour_next = BLANK;
        end else if (sky_s3) begin
            colour_next = SKY;
        end else if (offmap) begin
            colour_next = OFFMAP;
        end else if (opp_hit) begin
            colour_next = OPP;
        end else if (tile_odd) begin
            colour_next = CHECK_B;
        end else begin
            colour_next = CHECK_A;
        end
    end

    // Output register; stays black until a real pixel reaches the end of
    // the pipeline after reset
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pixel_out <= BLANK;
        end else begin
            pixel_out <= valid_s3 ? colour_next : BLANK;
        end
    end

endmodule

// File: tb/tb_forward_view.sv
// ---------------------------------------------------------------------------
// tb_forward_view
// Self-checking bench for forward_view. Each clock the inputs present at
// the edge are turned into an expected colour by a floating-point model of
// the projection and queued; the output three edges later is compared
// against the head of the queue. Directed steps override the model with
// hand-derived constants.
// ---------------------------------------------------------------------------
module tb_forward_view;

    localparam real PI = 3.14159265358979323846;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [8:0]  direction;
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic [10:0] opponent_x;
    logic [10:0] opponent_y;
    logic [11:0] pixel_out;

    int checks = 0;
    int passes = 0;

    logic [11:0] exp_q[$];
    string       tag_q[$];
    logic [11:0] cur_exp;
    string       cur_tag;

    always #5 clk_in = ~clk_in;

    forward_view dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .direction  (direction),
        .player_x   (player_x),
        .player_y   (player_y),
        .opponent_x (opponent_x),
        .opponent_y (opponent_y),
        .pixel_out  (pixel_out)
    );

    // Mathematical floor division for a positive divisor
    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) begin
            q = q - 1;
        end
        return q;
    endfunction

    // Nearest integer to 256*x, halves away from zero
    function automatic int to_q18(input real x);
        real s;
        s = 256.0 * x;
        if (s >= 0.0) begin
            return $rtoi(s + 0.5);
        end
        return -$rtoi(-s + 0.5);
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Behavioural projection straight from the geometric definition
    function automatic logic [11:0] model_pixel(input int h, input int v, input int dir,
                                                input int px, input int py,
                                                input int ox, input int oy);
        int r, d, hs, lat, s, c, wx, wy;
        real rad;
        if (h >= 1024 || v >= 768) return 12'h000;
        r = v - 384;
        if (r <= 0) return 12'h6AF;
        d = 16384 / r;
        if (d > 2047) d = 2047;
        hs  = h - 512;
        lat = floor_div(hs * d, 512);
        rad = real'(dir) * PI / 180.0;
        s   = to_q18($sin(rad));
        c   = to_q18($cos(rad));
        wx  = px + floor_div(d * c - lat * s, 256);
        wy  = py + floor_div(d * s + lat * c, 256);
        if (wx < 0 || wx > 2047 || wy < 0 || wy > 2047) return 12'h444;
`ifdef FORWARD_VIEW_OPPONENT_EN
        if (iabs(wx - ox) < 32 && iabs(wy - oy) < 32) return 12'hF00;
`else
        if (iabs(ox) < 0 || iabs(oy) < 0) return 12'hF00;
`endif
        if ((((wx / 64) + (wy / 64)) % 2) == 0) return 12'h0A0;
        return 12'h070;
    endfunction

    task automatic check_output(input logic [11:0] expected, input string tag);
        checks++;
        assert (pixel_out === expected) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s: pixel_out=%h expected=%h", tag, pixel_out, expected);
        end
    endtask

    // Drive one raster position; the expected colour comes from the model
    task automatic apply_stimulus(input int h, input int v, input int dir,
                                  input int px, input int py,
                                  input int ox, input int oy, input string tag);
        hcount_in  = 11'(h);
        vcount_in  = 10'(v);
        direction  = 9'(dir);
        player_x   = 11'(px);
        player_y   = 11'(py);
        opponent_x = 11'(ox);
        opponent_y = 11'(oy);
        cur_exp    = model_pixel(h, v, dir, px, py, ox, oy);
        cur_tag    = tag;
    endtask

    // One clock: record what the DUT samples now, check what it sampled
    // three edges ago (or black while the pipeline is still filling)
    task automatic tick();
        @(posedge clk_in);
        exp_q.push_back(cur_exp);
        tag_q.push_back(cur_tag);
        #1;
        if (exp_q.size() > 3) begin
            check_output(exp_q.pop_front(), tag_q.pop_front());
        end else begin
            check_output(12'h000, "pipeline_fill");
        end
    endtask

    task automatic random_pixel(input string tag);
        apply_stimulus($urandom_range(0, 1100), $urandom_range(300, 800),
                       $urandom_range(0, 511),
                       $urandom_range(0, 2047), $urandom_range(0, 2047),
                       $urandom_range(0, 2047), $urandom_range(0, 2047), tag);
    endtask

    initial begin
        rst_in = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, "idle");

        // Reset for one clock, output must be black throughout
        @(posedge clk_in);
        #1;
        check_output(12'h000, "in_reset");
        rst_in = 1'b0;
        $display("[TB] reset released");

        // Known scenes
        apply_stimulus(767, 767, 90, 960, 1920, 0, 0, "track_near");
        cur_exp = 12'h0A0;
        tick();
        apply_stimulus(767, 512, 90, 960, 1920, 0, 0, "offmap_wy2048");
        cur_exp = 12'h444;
        tick();
        apply_stimulus(500, 300, 90, 960, 1920, 0, 0, "sky_row300");
        cur_exp = 12'h6AF;
        tick();
        apply_stimulus(1100, 600, 90, 960, 1920, 0, 0, "hblank_1100");
        cur_exp = 12'h000;
        tick();
        apply_stimulus(512, 462, 270, 1328, 400, 1328, 191, "opponent_hit");
`ifdef FORWARD_VIEW_OPPONENT_EN
        cur_exp = 12'hF00;
`else
        cur_exp = 12'h0A0;
`endif
        tick();
        apply_stimulus(767, 767, 450, 960, 1920, 0, 0, "dir450_track");
        cur_exp = 12'h0A0;
        tick();
        apply_stimulus(767, 512, 450, 960, 1920, 0, 0, "dir450_offmap");
        cur_exp = 12'h444;
        tick();
        apply_stimulus(100, 768, 90, 960, 1920, 0, 0, "vblank_768");
        cur_exp = 12'h000;
        tick();
        apply_stimulus(100, 384, 90, 960, 1920, 0, 0, "horizon_sky");
        cur_exp = 12'h6AF;
        tick();
        apply_stimulus(1023, 385, 45, 1000, 1000, 0, 0, "depth_clamp");
        tick();
        apply_stimulus(0, 767, 180, 1024, 1024, 0, 0, "left_edge");
        tick();

        // Heading 90 and 450 must render the same pixels
        for (int i = 0; i < 20; i++) begin
            int h, v, px, py;
            h  = $urandom_range(0, 1023);
            v  = $urandom_range(385, 767);
            px = $urandom_range(0, 2047);
            py = $urandom_range(0, 2047);
            apply_stimulus(h, v, 90, px, py, 0, 0, "alias_90");
            tick();
            apply_stimulus(h, v, 450, px, py, 0, 0, "alias_450");
            tick();
        end

        // Random raster positions, headings and positions
        for (int i = 0; i < 200; i++) begin
            random_pixel("random_a");
            tick();
        end

        // Reset mid-stream: output clears at once and the pipe refills
        #2;
        rst_in = 1'b1;
        #1;
        check_output(12'h000, "async_reset");
        exp_q.delete();
        tag_q.delete();
        @(posedge clk_in);
        #1;
        check_output(12'h000, "reset_held");
        rst_in = 1'b0;

        for (int i = 0; i < 100; i++) begin
            random_pixel("random_b");
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
